// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the MEM pipeline stage
package mem_pkg;

   localparam int XLEN_DEF = 64;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - DEPTH x XLEN data array, async read, byte-enabled sync write
module data_mem_bank #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [XLEN/8-1:0] be,
   input  logic [AW-1:0]     addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_stage_p.sv
// rtl/mem_stage_p.sv - RV64 MEM stage: loads/stores with wait states, branch resolve, MEM/WB register
module mem_stage_p
   import mem_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int DEPTH       = 128,
   parameter int WAIT_STATES = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [XLEN-1:0] sum_in,
   input  logic            zero,
   input  logic            branch_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic            mem_to_reg_in,
   input  logic            reg_write_in,
   input  logic [2:0]      funct3_in,
   input  logic [XLEN-1:0] alu_result_in,
   input  logic [XLEN-1:0] read_data2_in,
   input  logic [4:0]      write_register_in,
   output logic            stall,
   output logic            wb_valid,
   output logic            pc_src,
   output logic [XLEN-1:0] sum_out,
   output logic [XLEN-1:0] read_data_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [4:0]      write_register_out,
   output logic            mem_to_reg_out,
   output logic            reg_write_out,
   output logic            misalign
);

   localparam int AW = $clog2(DEPTH);

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            stall_c, complete, mem_op, is_store, is_load, misal, we;
   logic [2:0]      lane;
   logic [7:0]      be_base, be;
   logic [XLEN-1:0] rword, shifted, load_val, wdata;
   logic            unused_addr_hi;

   assign lane           = alu_result_in[2:0];
   assign unused_addr_hi = ^alu_result_in[XLEN-1:3+AW];
   assign mem_op         = in_valid & (mem_read_in | mem_write_in);
   assign is_store       = mem_op & mem_write_in;
   assign is_load        = mem_op & ~mem_write_in;

   always_comb begin
      misal   = 1'b0;
      be_base = 8'h01;
      case (funct3_in[1:0])
         2'd0: be_base = 8'h01;
         2'd1: begin be_base = 8'h03; misal = lane[0];      end
         2'd2: begin be_base = 8'h0F; misal = |lane[1:0];   end
         default: begin be_base = 8'hFF; misal = |lane;     end
      endcase
      // funct3 111 has no load encoding; treat it like a faulting access
      if (is_load && funct3_in == 3'b111) misal = 1'b1;
      if (!mem_op) misal = 1'b0;
   end

   assign be      = be_base << lane;
   assign wdata   = read_data2_in << {lane, 3'b000};
   assign shifted = rword >> {lane, 3'b000};
   assign we      = complete & is_store & ~misal & rst_n;

   always_comb begin
      load_val = '0;
      case (funct3_in)
         F3_B:  load_val = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_H:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_W:  load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_D:  load_val = shifted;
         F3_BU: load_val = {{(XLEN-8){1'b0}},  shifted[7:0]};
         F3_HU: load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         F3_WU: load_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: load_val = '0;
      endcase
   end

   data_mem_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .addr  (alu_result_in[3 +: AW]),
      .wdata (wdata),
      .rdata (rword)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_op) begin
               if (WAIT_STATES == 0) begin
                  complete = 1'b1;
               end else begin
                  stall_c   = 1'b1;
                  state_nxt = ST_WAIT;
                  cnt_nxt   = 4'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt != 4'd0) begin
               stall_c = 1'b1;
               cnt_nxt = cnt - 4'd1;
            end else begin
               complete  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign stall = stall_c & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid           <= 1'b0;
         pc_src             <= 1'b0;
         sum_out            <= '0;
         read_data_out      <= '0;
         alu_result_out     <= '0;
         write_register_out <= '0;
         mem_to_reg_out     <= 1'b0;
         reg_write_out      <= 1'b0;
         misalign           <= 1'b0;
      end else if (stall_c) begin
         wb_valid <= 1'b0;
         pc_src   <= 1'b0;
      end else begin
         wb_valid           <= in_valid;
         pc_src             <= in_valid & branch_in & zero;
         sum_out            <= sum_in;
         read_data_out      <= (is_load & ~misal) ? load_val : '0;
         alu_result_out     <= alu_result_in;
         write_register_out <= write_register_in;
         mem_to_reg_out     <= mem_to_reg_in;
         reg_write_out      <= reg_write_in & ~misal;
         misalign           <= misal;
      end
   end

endmodule
